mac_dot_seq: RTL
================

// Module: mac_dot_seq
// PURPOSE
//  Sequencer around a shared unsigned multiply-accumulate datapath: runs one dot-product job at a time.
//  Accepts a job (vector length), streams (a,b) operand pairs over a valid/ready handshake,
//  accumulates sum(a*b) and presents the result on a valid/ready output.
//  Sits between a stream source (RAM reader / host FIFO) and the result consumer.
// PARAMETERS
//  DATA_WIDTH  4   operand width, unsigned
//  ACC_WIDTH   16  accumulator/result width; must be >= 2*DATA_WIDTH
//  LEN_WIDTH   4   job length field width; elements per job = len+1 (1..2^LEN_WIDTH)
// PORTS
//  clk        in   1           clock, all logic on posedge
//  reset      in   1           synchronous, active-high
//  start      in   1           job request; accepted only in IDLE
//  len        in   LEN_WIDTH   elements-1; sampled on accepted start
//  busy       out  1           1 in RUN or DONE
//  in_valid   in   1           operand pair valid
//  in_ready   out  1           1 only in RUN
//  in_a       in   DATA_WIDTH  operand a
//  in_b       in   DATA_WIDTH  operand b
//  out_valid  out  1           result valid; 1 only in DONE
//  out_ready  in   1           consumer accepts result
//  out_data   out  ACC_WIDTH   accumulated result
//  overflow   out  1           sticky per job; set if any accumulate exceeded 2^ACC_WIDTH-1
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, count=0, overflow=0, busy=0, in_ready=0, out_valid=0, out_data=0.
//  Reset mid-job: abort immediately, partial sum discarded, no out_valid.
//  FSM: IDLE -(start)-> RUN: latch len, clear acc, count, overflow.
//   RUN: beat = in_valid & in_ready; on beat acc <= acc + zext(a*b), count++.
//   RUN -(beat with count==len)-> DONE; out_valid=1 on the cycle after the last beat (1-cycle latency).
//   DONE: out_data=acc, overflow stable; held until out_ready; DONE -(out_ready)-> IDLE.
//  start outside IDLE ignored (incl. DONE cycle with out_ready=1); next start accepted no earlier than cycle after return to IDLE.
//  in_valid outside RUN ignored; no beat consumed. in_valid gaps in RUN stall; acc and count hold.
//  Product 2*DATA_WIDTH bits, zero-extended to ACC_WIDTH+1 for carry detection; carry out sets overflow.
//  len=0: exactly one beat, then DONE.
// CONFIGURATION
//  MAC_DOT_SAT_EN defined: on carry out, acc clamps to all-ones and stays there for the rest of the job; overflow still set.
//  Not defined: acc wraps modulo 2^ACC_WIDTH; overflow set.
// STRUCTURE
//  mac_dot_pkg: state encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2; width check constant 2*DATA_WIDTH.
//  Sub-module mac_dot_acc: accumulator datapath with clr, en, a, b -> acc, ovf; holds the SAT_EN logic.
//  Top: FSM, beat counter, handshakes.
// TESTING
//  1. start len=2, pairs (1,2),(3,4),(5,6) back-to-back -> out_valid 1 cycle after 3rd beat, out_data=44, overflow=0.
//  2. Same job with in_valid gaps; out_ready low 5 cycles -> out_data=44 held stable, in_ready=0 in DONE.
//  3. ACC_WIDTH=8, len=1, pairs (15,15),(15,15): without SAT_EN -> 194, overflow=1; with SAT_EN -> 255, overflow=1.
//  4. reset after 1 beat of a len=3 job -> IDLE, busy=0; next job len=0 (7,9) -> 63, overflow=0.
//  5. start pulsed during RUN and in DONE with out_ready=1 -> ignored; start next cycle accepted, busy=1.
//  6. in_valid=1 while IDLE/DONE -> no accumulation; the following job's result is unaffected.

Source files
------------

// File: rtl/mac_dot_pkg.sv
// Shared definitions for the mac_dot sequencer: FSM state encoding and the product width rule.
// Optional build macro MAC_DOT_SAT_EN (saturating accumulate) is consumed in mac_dot_acc.
package mac_dot_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Full-precision product width; the accumulator must be at least this wide.
    function automatic int prod_width(input int data_width);
        return 2 * data_width;
    endfunction

endpackage

// File: rtl/mac_dot_acc.sv
// Unsigned multiply-accumulate datapath with carry-out detection and a sticky overflow flag.
// Define MAC_DOT_SAT_EN to clamp the accumulator at all-ones after a carry instead of wrapping.
module mac_dot_acc
    import mac_dot_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [ACC_WIDTH-1:0]  acc,
    output logic                  ovf
);

    localparam int PROD_W = prod_width(DATA_WIDTH);
    localparam int SUM_W  = ACC_WIDTH + 1;

    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [PROD_W-1:0]    prod;
    logic [SUM_W-1:0]     sum;
    logic                 carry;

    always_comb begin
        prod  = PROD_W'(a) * PROD_W'(b);
        sum   = {1'b0, acc_q} + SUM_W'(prod);
        carry = sum[ACC_WIDTH];
        acc_d = acc_q;
        ovf_d = ovf_q;
        if (clr) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end else if (en) begin
            ovf_d = ovf_q | carry;
`ifdef MAC_DOT_SAT_EN
            // Once clamped, the sum stays pinned for the remainder of the job.
            if (carry || ovf_q) begin
                acc_d = '1;
            end else begin
                acc_d = sum[ACC_WIDTH-1:0];
            end
`else
            acc_d = sum[ACC_WIDTH-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc = acc_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/mac_dot_seq.sv
// Dot-product job sequencer: accepts a job length, streams operand pairs into mac_dot_acc, hands off the sum.
// Build option MAC_DOT_SAT_EN selects a saturating accumulator (see mac_dot_acc).
module mac_dot_seq
    import mac_dot_pkg::*;
#(
    parameter int DATA_WIDTH = 4,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic                  overflow
);

    logic [1:0]           state_q, state_d;
    logic [LEN_WIDTH-1:0] len_q, len_d;
    logic [LEN_WIDTH-1:0] count_q, count_d;
    logic                 beat;
    logic                 acc_clr;
    logic [ACC_WIDTH-1:0] acc;
    logic                 acc_ovf;

    assign beat = in_valid && (state_q == ST_RUN);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        count_d = count_q;
        acc_clr = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    len_d   = len;
                    count_d = '0;
                    acc_clr = 1'b1;
                end
            end
            ST_RUN: begin
                if (beat) begin
                    count_d = count_q + 1'b1;
                    if (count_q == len_q) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                // start is deliberately not looked at here, even when the result leaves this cycle.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            len_q   <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            count_q <= count_d;
        end
    end

    mac_dot_acc #(
        .DATA_WIDTH(DATA_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_acc (
        .clk  (clk),
        .reset(reset),
        .clr  (acc_clr),
        .en   (beat),
        .a    (in_a),
        .b    (in_b),
        .acc  (acc),
        .ovf  (acc_ovf)
    );

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign in_ready  = (state_q == ST_RUN);
    assign out_valid = (state_q == ST_DONE);
    assign out_data  = (state_q == ST_DONE) ? acc : '0;
    assign overflow  = acc_ovf;

endmodule
